any1_inst_align_queue: RTL

//  Sits between the I-cache fetch stage and decode. Accepts one fetched 512-bit line plus ip/pip/Stream/predict_taken
//  (sInstAlignIn) per handshake, extracts the 32-bit instruction at ip and buffers it (sInstAlignOut) in a small FIFO.

---
 rtl/any1_pkg.sv | 35 +++
 rtl/any1_inst_extract.sv | 24 ++
 rtl/any1_inst_align_queue.sv | 103 ++++++++++
 3 files changed

// File: rtl/any1_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | any1_pkg : shared fetch/align types and constants for the ANY1 front end |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
package any1_pkg;

   typedef logic [31:0] Instruction;

   localparam Instruction NOP_INSN = 32'h3F3F3F3F;
   localparam logic [7:0] FLT_IADR = 8'h36;

   typedef struct packed {
      logic [511:0] cacheline;
      logic [31:0]  ip;
      logic [31:0]  pip;
      logic [3:0]   stream;
      logic         predict_taken;
   } sInstAlignIn;

   typedef struct packed {
      Instruction  ir;
      logic [31:0] ip;
      logic [31:0] pip;
      logic [3:0]  stream;
      logic        predict_taken;
   } sInstAlignOut;

   typedef struct packed {
      sInstAlignOut ent;
      logic         iadr;
   } sInstQEntry;

endpackage
`default_nettype wire

// File: rtl/any1_inst_extract.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | any1_inst_extract : picks the 32-bit word at ip out of a 512-bit line    |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
module any1_inst_extract
   import any1_pkg::*;
#(
   parameter Instruction NOP_IR = NOP_INSN
) (
   input  logic [511:0] cacheline_i,
   input  logic [5:0]   ip_i,
   output Instruction   ir_o,
   output logic         iadr_o
);

   // A misaligned ip has no valid word; hand decode a NOP and flag the fault.
   always_comb begin
      iadr_o = |ip_i[1:0];
      ir_o   = iadr_o ? NOP_IR : cacheline_i[{ip_i[5:2], 5'b0} +: 32];
   end

endmodule
`default_nettype wire

// File: rtl/any1_inst_align_queue.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | any1_inst_align_queue : extracts fetched instructions and queues them    |
// | for decode; a redirect flush empties the queue in one cycle.             |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
module any1_inst_align_queue
   import any1_pkg::*;
#(
   parameter int         DEPTH  = 4,
   parameter Instruction NOP_IR = NOP_INSN
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  sInstAlignIn                in_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output sInstAlignOut               out_o,
   output logic                       out_iadr_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   sInstQEntry    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ready_q, ready_d;
   logic          push, pop;
   Instruction    ext_ir;
   logic          ext_iadr;
   sInstQEntry    entry_d;

   any1_inst_extract #(
      .NOP_IR (NOP_IR)
   ) u_extract (
      .cacheline_i (in_i.cacheline),
      .ip_i        (in_i.ip[5:0]),
      .ir_o        (ext_ir),
      .iadr_o      (ext_iadr)
   );

   always_comb begin
      entry_d                   = '0;
      entry_d.ent.ir            = ext_ir;
      entry_d.ent.ip            = in_i.ip;
      entry_d.ent.pip           = in_i.pip;
      entry_d.ent.stream        = in_i.stream;
      entry_d.ent.predict_taken = in_i.predict_taken;
      entry_d.iadr              = ext_iadr;
   end

   // Ready is registered, so a full queue never accepts even if decode pops this cycle.
   always_comb begin
      push     = in_valid_i & ready_q & ~flush_i;
      pop      = (count_q != '0) & out_ready_i & ~flush_i;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (!push && pop) count_d = count_q - CW'(1);
      end
      ready_d = (count_d != CW'(DEPTH));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b1;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
         if (push) mem_q[wr_ptr_q] <= entry_d;
      end
   end

   always_comb begin
      in_ready_o  = ready_q;
      out_valid_o = (count_q != '0);
      out_o       = mem_q[rd_ptr_q].ent;
      out_iadr_o  = mem_q[rd_ptr_q].iadr;
      count_o     = count_q;
   end

endmodule
`default_nettype wire
